// File: rtl/i2c_master.sv
// Single-master I2C controller: START, 7-bit address + R/W, one data byte
// written or read, STOP. SCL comes from a fixed divider of CLK; SDA is
// open-drain through SDA_oe (drive low) and SDA_in (sensed level).
module i2c_master #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       start,
  input  logic       rw,
  input  logic [6:0] slave_addr,
  input  logic [7:0] data_in,
  output logic [7:0] data_out,
  output logic       busy,
  output logic       done,
  output logic       ack_error,
  output logic       SCL,
  output logic       SDA_oe,
  input  logic       SDA_in
);

  localparam int unsigned QW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [QW-1:0] QMAX = QW'(CLK_DIV - 1);

  typedef enum logic [3:0] {
    S_IDLE,
    S_START,
    S_ADDR,
    S_ADDR_ACK,
    S_WRITE,
    S_WRITE_ACK,
    S_READ,
    S_READ_NACK,
    S_STOP
  } state_t;

  state_t        state_q;
  logic [QW-1:0] qcnt_q;
  logic [1:0]    ph_q;
  logic [2:0]    bit_q;
  logic [7:0]    sh_q;
  logic [6:0]    rx_q;
  logic [7:0]    data_q;
  logic          rw_q;
  logic [7:0]    dout_q;
  logic          busy_q;
  logic          done_q;
  logic          ack_err_q;
  logic          scl_q;
  logic          oe_q;
  logic          qwrap_d;

  // End of a quarter period: the phase counter advances on this cycle's edge.
  always_comb begin
    qwrap_d = (qcnt_q == QMAX);
  end

  // Transaction FSM with timebase; SCL/SDA_oe are registered for the phase being entered.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= S_IDLE;
      qcnt_q    <= '0;
      ph_q      <= '0;
      bit_q     <= '0;
      sh_q      <= '0;
      rx_q      <= '0;
      data_q    <= '0;
      rw_q      <= 1'b0;
      dout_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ack_err_q <= 1'b0;
      scl_q     <= 1'b1;
      oe_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (state_q == S_IDLE) begin
        qcnt_q <= '0;
        ph_q   <= '0;
        scl_q  <= 1'b1;
        oe_q   <= 1'b0;
        if (start) begin
          sh_q      <= {slave_addr, rw};
          rw_q      <= rw;
          data_q    <= data_in;
          ack_err_q <= 1'b0;
          busy_q    <= 1'b1;
          state_q   <= S_START;
        end
      end else if (!qwrap_d) begin
        qcnt_q <= qcnt_q + QW'(1);
      end else begin
        qcnt_q <= '0;
        if (ph_q != 2'd3) begin
          ph_q <= ph_q + 2'd1;
          // Entering q2: SCL rises; START pulls SDA low under a high SCL.
          if (ph_q == 2'd1) begin
            scl_q <= 1'b1;
            if (state_q == S_START) oe_q <= 1'b1;
          end
          // Entering q3: sample SDA in the middle of the high phase.
          if (ph_q == 2'd2) begin
            case (state_q)
              S_ADDR_ACK, S_WRITE_ACK: if (SDA_in) ack_err_q <= 1'b1;
              S_READ: begin
                rx_q <= {rx_q[5:0], SDA_in};
                if (bit_q == 3'd0) dout_q <= {rx_q, SDA_in};
              end
              S_STOP: oe_q <= 1'b0;
              default: ;
            endcase
          end
        end else begin
          // End of bit period: choose the next bit and its q0 drive.
          ph_q  <= 2'd0;
          scl_q <= 1'b0;
          case (state_q)
            S_START: begin
              state_q <= S_ADDR;
              bit_q   <= 3'd7;
              oe_q    <= ~sh_q[7];
            end
            S_ADDR, S_WRITE: begin
              if (bit_q == 3'd0) begin
                state_q <= (state_q == S_ADDR) ? S_ADDR_ACK : S_WRITE_ACK;
                oe_q    <= 1'b0;
              end else begin
                bit_q <= bit_q - 3'd1;
                sh_q  <= {sh_q[6:0], 1'b0};
                oe_q  <= ~sh_q[6];
              end
            end
            S_ADDR_ACK: begin
              bit_q <= 3'd7;
              if (ack_err_q) begin
                state_q <= S_STOP;
                oe_q    <= 1'b1;
              end else if (rw_q) begin
                state_q <= S_READ;
                oe_q    <= 1'b0;
              end else begin
                state_q <= S_WRITE;
                sh_q    <= data_q;
                oe_q    <= ~data_q[7];
              end
            end
            S_WRITE_ACK, S_READ_NACK: begin
              state_q <= S_STOP;
              oe_q    <= 1'b1;
            end
            S_READ: begin
              oe_q <= 1'b0;
              if (bit_q == 3'd0) state_q <= S_READ_NACK;
              else bit_q <= bit_q - 3'd1;
            end
            S_STOP: begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              scl_q   <= 1'b1;
              oe_q    <= 1'b0;
            end
            default: state_q <= S_IDLE;
          endcase
        end
      end
    end
  end

  assign data_out  = dout_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign ack_error = ack_err_q;
  assign SCL       = scl_q;
  assign SDA_oe    = oe_q;

endmodule

// File: tb/tb_i2c_master.sv
// Directed bench for i2c_master with a behavioural open-drain slave and a
// bus monitor that captures SDA on every SCL rise and counts START/STOP.
module tb_i2c_master;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       start = 1'b0;
  logic       rw = 1'b0;
  logic [6:0] slave_addr = '0;
  logic [7:0] data_in = '0;
  logic [7:0] data_out;
  logic       busy, done, ack_error, SCL, SDA_oe;
  logic       sda;
  logic       slave_low = 1'b0;

  int checks = 0;
  int failures = 0;

  // slave configuration
  logic       s_ack_addr = 1'b1;
  logic       s_ack_data = 1'b1;
  logic       s_rw = 1'b0;
  logic [7:0] s_rbyte = '0;

  // monitor state (free running; tests take snapshots)
  int          rises = 0;
  int          rise_base = 0;
  logic [31:0] cap = '0;
  int          starts = 0;
  int          stops = 0;
  logic        scl_p = 1'b1;
  logic        sda_p = 1'b1;

  assign sda = ~(SDA_oe | slave_low);

  i2c_master #(.CLK_DIV(4)) dut (
    .CLK(CLK), .RST(RST), .start(start), .rw(rw), .slave_addr(slave_addr),
    .data_in(data_in), .data_out(data_out), .busy(busy), .done(done),
    .ack_error(ack_error), .SCL(SCL), .SDA_oe(SDA_oe), .SDA_in(sda)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Slave pull-down for SCL bit number j (1-based within a transaction).
  function automatic logic slave_pull(input int j);
    logic [2:0] k;
    if (j == 9) return s_ack_addr;
    if (!s_ack_addr) return 1'b0;
    if (!s_rw && j == 18) return s_ack_data;
    if (s_rw && j >= 10 && j <= 17) begin
      k = 3'(17 - j);
      return ~s_rbyte[k];
    end
    return 1'b0;
  endfunction

  always @(posedge SCL) begin
    cap   = {cap[30:0], sda};
    rises = rises + 1;
  end

  always @(negedge SCL) slave_low = slave_pull(rises - rise_base + 1);

  always @(negedge CLK) begin
    if (scl_p && SCL && sda_p && !sda) starts = starts + 1;
    if (scl_p && SCL && !sda_p && sda) stops = stops + 1;
    scl_p = SCL;
    sda_p = sda;
  end

  task automatic issue(input logic [6:0] a, input logic r, input logic [7:0] d);
    @(negedge CLK);
    rise_base = rises;
    slave_addr = a; rw = r; data_in = d; start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
  endtask

  task automatic wait_done(input int from, output int lat);
    logic seen;
    seen = 1'b0;
    lat = from;
    while (!seen && lat < 2000) begin
      @(posedge CLK);
      lat++;
      #1;
      if (done) seen = 1'b1;
    end
    chk("done_seen", 32'(seen), 32'd1);
  endtask

  int lat, st0, sp0, n;

  initial begin
    // reset values
    #3 RST = 1'b1;
    @(negedge CLK);
    chk("rst_scl", 32'(SCL), 32'd1);
    chk("rst_oe", 32'(SDA_oe), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_ackerr", 32'(ack_error), 32'd0);
    chk("rst_dout", 32'(data_out), 32'h00);
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    repeat (3) @(negedge CLK);

    // write with ACK
    s_ack_addr = 1; s_ack_data = 1; s_rw = 0;
    st0 = starts; sp0 = stops;
    issue(7'h59, 1'b0, 8'h5A);
    chk("wr_busy", 32'(busy), 32'd1);
    wait_done(0, lat);
    chk("wr_lat", 32'(lat), 32'd320);
    chk("wr_busy_end", 32'(busy), 32'd0);
    chk("wr_ackerr", 32'(ack_error), 32'd0);
    chk("wr_rises", 32'(rises - rise_base), 32'd19);
    chk("wr_bits", {13'd0, cap[18:0]}, {13'd0, 8'hB2, 1'b0, 8'h5A, 1'b0, 1'b0});
    chk("wr_start", 32'(starts - st0), 32'd1);
    chk("wr_stop", 32'(stops - sp0), 32'd1);
    @(posedge CLK); #1;
    chk("wr_done_pulse", 32'(done), 32'd0);

    // read
    s_rw = 1; s_rbyte = 8'hA5;
    st0 = starts; sp0 = stops;
    issue(7'h59, 1'b1, 8'h00);
    wait_done(0, lat);
    chk("rd_lat", 32'(lat), 32'd320);
    chk("rd_dout", 32'(data_out), 32'hA5);
    chk("rd_ackerr", 32'(ack_error), 32'd0);
    chk("rd_bits", {13'd0, cap[18:0]}, {13'd0, 8'hB3, 1'b0, 8'hA5, 1'b1, 1'b0});
    chk("rd_stop", 32'(stops - sp0), 32'd1);

    // address NACK
    s_ack_addr = 0; s_rw = 0;
    st0 = starts; sp0 = stops;
    issue(7'h59, 1'b0, 8'h00);
    wait_done(0, lat);
    chk("an_lat", 32'(lat), 32'd176);
    chk("an_ackerr", 32'(ack_error), 32'd1);
    chk("an_dout", 32'(data_out), 32'hA5);
    chk("an_rises", 32'(rises - rise_base), 32'd10);
    chk("an_bits", {22'd0, cap[9:0]}, {22'd0, 8'hB2, 1'b1, 1'b0});
    chk("an_stop", 32'(stops - sp0), 32'd1);

    // write-data NACK
    s_ack_addr = 1; s_ack_data = 0;
    st0 = starts; sp0 = stops;
    issue(7'h59, 1'b0, 8'hC3);
    chk("dn_ackerr_clr", 32'(ack_error), 32'd0);
    wait_done(0, lat);
    chk("dn_lat", 32'(lat), 32'd320);
    chk("dn_ackerr", 32'(ack_error), 32'd1);
    chk("dn_bits", {13'd0, cap[18:0]}, {13'd0, 8'hB2, 1'b0, 8'hC3, 1'b1, 1'b0});
    chk("dn_stop", 32'(stops - sp0), 32'd1);

    // start while busy is ignored; start in the done cycle is accepted
    s_ack_data = 1;
    issue(7'h2A, 1'b0, 8'h3C);
    repeat (99) @(posedge CLK);
    @(negedge CLK);
    slave_addr = 7'h12; rw = 1'b1; data_in = 8'hFF; start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    chk("bz_busy", 32'(busy), 32'd1);
    wait_done(100, lat);
    chk("bz_lat", 32'(lat), 32'd320);
    chk("bz_bits", {13'd0, cap[18:0]}, {13'd0, 8'h54, 1'b0, 8'h3C, 1'b0, 1'b0});
    chk("bz_ackerr", 32'(ack_error), 32'd0);
    rise_base = rises;
    slave_addr = 7'h59; rw = 1'b0; data_in = 8'h81; start = 1'b1;
    @(posedge CLK); #1;
    start = 1'b0;
    chk("dc_accept", 32'(busy), 32'd1);
    wait_done(0, lat);
    chk("dc_lat", 32'(lat), 32'd320);
    chk("dc_bits", {13'd0, cap[18:0]}, {13'd0, 8'hB2, 1'b0, 8'h81, 1'b0, 1'b0});

    // reset during WRITE bit 3 high phase
    issue(7'h59, 1'b0, 8'hF0);
    n = 0;
    while ((rises - rise_base) < 14 && n < 2000) begin
      @(negedge CLK);
      n++;
    end
    chk("rs_reached", 32'(rises - rise_base), 32'd14);
    @(negedge CLK);
    chk("rs_pre_scl", 32'(SCL), 32'd1);
    chk("rs_pre_busy", 32'(busy), 32'd1);
    #2 RST = 1'b1;
    #1;
    chk("rs_scl", 32'(SCL), 32'd1);
    chk("rs_oe", 32'(SDA_oe), 32'd0);
    chk("rs_busy", 32'(busy), 32'd0);
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    repeat (2) @(negedge CLK);
    st0 = starts; sp0 = stops;
    issue(7'h59, 1'b0, 8'h5A);
    wait_done(0, lat);
    chk("rs_wr_lat", 32'(lat), 32'd320);
    chk("rs_wr_bits", {13'd0, cap[18:0]}, {13'd0, 8'hB2, 1'b0, 8'h5A, 1'b0, 1'b0});
    chk("rs_wr_ackerr", 32'(ack_error), 32'd0);
    chk("rs_wr_start", 32'(starts - st0), 32'd1);
    chk("rs_wr_stop", 32'(stops - sp0), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=%0d exp=0", 1);
    $fatal(1);
  end

endmodule
